// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the FIFO-to-stream reader: FSM states and parameter defaults.
package fifo_stream_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_PKT_LEN    = 8;

  // IDLE: nothing buffered or in flight. FETCH: reading/delivering with enable=1.
  // DRAIN: enable dropped, still delivering already-fetched words.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry FIFO-ordered skid buffer. Entry 0 is always the head.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int W = DEF_DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_head,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_e0;
  logic [W-1:0] r_e1;
  logic [1:0]   r_occ;
  logic         w_pop;
  logic         w_push;

  // A pop needs data; a push into a full buffer is only taken alongside a pop.
  assign w_pop  = i_pop & (r_occ != 2'd0);
  assign w_push = i_push & ((r_occ != 2'd2) | w_pop);

  // Shift the entries so order is preserved under simultaneous push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_occ <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_e0 <= r_e1;
            r_e1 <= i_din;
          end else begin
            r_e0 <= i_din;
          end
        end
        2'b10: begin
          if (r_occ == 2'd0) r_e0 <= i_din;
          else               r_e1 <= i_din;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_occ <= r_occ - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_head = r_e0;
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous-read FIFO and presents the words as a packetised valid/ready stream.
// Handshake: a beat transfers on a rising edge where m_valid=1 and m_ready=1; while
// m_valid=1 and m_ready=0, m_data and m_last hold their values.
module fifo_stream_reader
  import fifo_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PKT_LEN    = DEF_PKT_LEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_read_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [15:0]           pkt_count,
  output logic                  busy,
  output state_e                o_dbg_state
);

  localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

  logic        r_inflight;
  logic        r_armed;
  logic [15:0] r_beat_cnt;
  logic [15:0] r_pkt_count;
  state_e      r_state;
  state_e      w_next_state;
  logic [1:0]  w_occ;
  logic        w_pop;
  logic [2:0]  w_pending;

  stream_skid_buf #(.W(DATA_WIDTH)) u_buf (
    .clk    (clk),
    .rst_n  (reset),
    .i_push (r_inflight),
    .i_pop  (w_pop),
    .i_din  (fifo_dout),
    .o_head (m_data),
    .o_occ  (w_occ)
  );

  assign m_valid   = (w_occ != 2'd0);
  assign w_pop     = m_valid & m_ready;
  assign busy      = r_inflight | m_valid;
  assign m_last    = m_valid & (r_beat_cnt == LAST_IDX);
  assign pkt_count = r_pkt_count;

  // Words already owed to the buffer after this edge's pop; never let it exceed 2.
  assign w_pending    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign fifo_read_en = r_armed & enable & ~fifo_empty & (w_pending < 3'd2);

  // Read pipeline: inflight mirrors the previous read; armed keeps reads off for one cycle after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
      r_armed    <= 1'b0;
    end else begin
      r_inflight <= fifo_read_en;
      r_armed    <= 1'b1;
    end
  end

  // Beat and packet counters advance on every accepted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_beat_cnt  <= 16'd0;
      r_pkt_count <= 16'd0;
    end else if (w_pop) begin
      if (m_last) begin
        r_beat_cnt  <= 16'd0;
        r_pkt_count <= r_pkt_count + 16'd1;
      end else begin
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // FSM next state; an empty FIFO alone never moves the state.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (fifo_read_en) w_next_state = FETCH;
      end
      FETCH: begin
        if (!enable)                    w_next_state = busy ? DRAIN : IDLE;
        else if (!busy && !fifo_read_en) w_next_state = IDLE;
      end
      DRAIN: begin
        if (enable)     w_next_state = FETCH;
        else if (!busy) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a FIFO model feeds the DUT and a queue-based model
// predicts read requests, stream beats, packet boundaries and counters.
module tb_fifo_stream_reader;
  import fifo_stream_pkg::*;

  localparam int W  = 32;
  localparam int PL = 8;
  localparam int W1 = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, enable, fifo_empty, m_ready;
  logic [W-1:0]  fifo_dout, m_data;
  logic          fifo_read_en, m_valid, m_last, busy;
  logic [15:0]   pkt_count;
  state_e        dbg_state;

  logic          rst1, en1, emp1, rdy1;
  logic [W1-1:0] dout1, data1;
  logic          ren1, valid1, last1, busy1;
  logic [15:0]   pkt1;
  state_e        dbg1;

  fifo_stream_reader #(.DATA_WIDTH(W), .PKT_LEN(PL)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_read_en(fifo_read_en), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .pkt_count(pkt_count),
    .busy(busy), .o_dbg_state(dbg_state)
  );

  fifo_stream_reader #(.DATA_WIDTH(W1), .PKT_LEN(1)) u_dut1 (
    .clk(clk), .reset(rst1), .enable(en1), .fifo_empty(emp1),
    .fifo_dout(dout1), .fifo_read_en(ren1), .m_valid(valid1),
    .m_ready(rdy1), .m_data(data1), .m_last(last1), .pkt_count(pkt1),
    .busy(busy1), .o_dbg_state(dbg1)
  );

  // ---------------- scoreboard state ----------------
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           rdy_q[$];
  int           cyc = 0;
  bit           started = 0;
  logic [W-1:0] dout_next = '0;
  int           exp_beat = 0;
  int           exp_pkts = 0;
  int           pops_total = 0;
  int           lasts_seen = 0;
  int           first_read_cyc = -1;
  int           first_valid_cyc = -1;
  bit           last_ren = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_words(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + W'(i));
  endtask

  // One clock cycle: called at a falling edge, returns at the next falling edge.
  task automatic step();
    bit exp_valid, pop_now, exp_ren;
    fifo_dout  = dout_next;
    fifo_empty = (fifo_q.size() == 0);
    #1;
    exp_valid = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
    check_val("m_valid", m_valid, exp_valid);
    if (exp_valid) begin
      check_val("m_data", m_data, exp_q[0]);
      check_val("m_last", m_last, (exp_beat == PL - 1));
    end else begin
      check_val("m_last_idle", m_last, 0);
    end
    if (m_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    pop_now = exp_valid && m_ready;
    exp_ren = started && enable && (fifo_q.size() > 0) && ((exp_q.size() - int'(pop_now)) < 2);
    check_val("fifo_read_en", fifo_read_en, exp_ren);
    check_val("busy", busy, (exp_q.size() > 0));
    check_val("pkt_count", pkt_count, exp_pkts[15:0]);
    last_ren = (fifo_read_en === 1'b1);
    if (pop_now) begin
      if (m_last === 1'b1) lasts_seen++;
      void'(exp_q.pop_front());
      void'(rdy_q.pop_front());
      pops_total++;
      if (exp_beat == PL - 1) begin
        exp_beat = 0;
        exp_pkts = (exp_pkts + 1) % 65536;
      end else begin
        exp_beat++;
      end
    end
    dout_next = $urandom;
    if (last_ren && fifo_q.size() > 0) begin
      dout_next = fifo_q.pop_front();
      exp_q.push_back(dout_next);
      rdy_q.push_back(cyc + 2);
      if (first_read_cyc < 0) first_read_cyc = cyc;
      check_val("outstanding_le2", (exp_q.size() <= 2), 1);
    end
    @(posedge clk);
    started = (reset === 1'b1);
    cyc++;
    @(negedge clk);
  endtask

  // Assert reset at a falling edge, check the forced values, release two cycles later.
  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check_val("rst_m_valid", m_valid, 0);
    check_val("rst_m_last", m_last, 0);
    check_val("rst_m_data", m_data, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_read_en", fifo_read_en, 0);
    check_val("rst_pkt_count", pkt_count, 0);
    check_val("rst_state", 32'(dbg_state), 32'(IDLE));
    fifo_q.delete();
    exp_q.delete();
    rdy_q.delete();
    exp_beat = 0;
    exp_pkts = 0;
    started  = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base;
    bit got;
    int beats;
    bit all_last;
    bit seen_wrap_m1;

    reset = 1'b0; enable = 1'b0; fifo_empty = 1'b1; m_ready = 1'b0; fifo_dout = '0;
    rst1 = 1'b0; en1 = 1'b1; emp1 = 1'b0; rdy1 = 1'b1; dout1 = '0;
    @(negedge clk);
    apply_reset();

    // Empty FIFO with enable and ready high: nothing happens.
    enable = 1'b1; m_ready = 1'b1;
    repeat (10) step();
    check_val("empty_state_idle", 32'(dbg_state), 32'(IDLE));

    // Eight preloaded words, ready always high.
    first_read_cyc = -1; first_valid_cyc = -1; lasts_seen = 0;
    load_words(32'hA0, 8);
    repeat (14) step();
    check_val("first_beat_latency", first_valid_cyc - first_read_cyc, 2);
    check_val("lasts_in_pkt", lasts_seen, 1);
    check_val("pkt_after_8", pkt_count, 1);

    // Same preload with ready toggling.
    base = pops_total;
    load_words(32'hA0, 8);
    for (int i = 0; i < 30; i++) begin
      m_ready = (i % 2 == 0);
      step();
    end
    check_val("toggle_beats", pops_total - base, 8);
    check_val("pkt_after_toggle", pkt_count, 2);

    // Enable dropped the cycle after the first read.
    enable = 1'b0; m_ready = 1'b1;
    load_words(32'h5000, 8);
    step();
    enable = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = last_ren;
    end
    check_val("drain_read_seen", got, 1);
    enable = 1'b0;
    base = pops_total;
    check_val("drain_state_fetch", 32'(dbg_state), 32'(FETCH));
    step();
    check_val("drain_state_drain", 32'(dbg_state), 32'(DRAIN));
    repeat (4) step();
    check_val("drain_state_idle", 32'(dbg_state), 32'(IDLE));
    check_val("drain_busy", busy, 0);
    check_val("drain_delivered", pops_total - base, 1);
    check_val("drain_no_more_reads", fifo_q.size(), 7);
    enable = 1'b1;
    repeat (20) step();
    check_val("pkt_after_drain", pkt_count, 3);

    // Reset in the middle of a packet, then a fresh packet.
    load_words(32'h7700, 8);
    base = pops_total;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      step();
      got = (pops_total - base >= 3);
    end
    check_val("midpkt_three_beats", got, 1);
    apply_reset();
    load_words(32'hB0, 8);
    enable = 1'b1; m_ready = 1'b1; lasts_seen = 0;
    repeat (16) step();
    check_val("post_reset_pkt", pkt_count, 1);
    check_val("post_reset_lasts", lasts_seen, 1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      enable  = ($urandom_range(0, 9) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) fifo_q.push_back($urandom);
      step();
    end
    enable = 1'b1; m_ready = 1'b1;
    repeat (60) step();
    check_val("random_drained", busy, 0);
    check_val("random_pkt_final", pkt_count, exp_pkts[15:0]);

    // PKT_LEN=1 instance: every beat is last, 65536 packets wrap the count.
    beats = 0; all_last = 1; seen_wrap_m1 = 0;
    rst1 = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(negedge clk);
      dout1 = W1'($urandom);
      #1;
      if (beats == 65535 && !seen_wrap_m1) begin
        check_val("len1_pkt_65535", pkt1, 16'hFFFF);
        seen_wrap_m1 = 1;
      end
      if (beats == 65536) begin
        check_val("len1_pkt_wrap", pkt1, 0);
        break;
      end
      if (valid1 === 1'b1 && rdy1 === 1'b1) begin
        beats++;
        if (last1 !== 1'b1) all_last = 0;
      end
    end
    check_val("len1_beats", beats, 65536);
    check_val("len1_all_last", all_last, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Parameters
REQ-001 DATA_WIDTH, 32, width of FIFO read data and stream data.
REQ-002 PKT_LEN, 8, beats per packet; m_last marks every PKT_LEN-th beat; legal range 1..65535.

Interface
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
REQ-005 enable  in  1  1 = issue FIFO reads; 0 = stop new reads, drain already-fetched data.
REQ-006 fifo_empty  in  1  empty flag from the FIFO read side.
REQ-007 fifo_dout  in  DATA_WIDTH  FIFO read data, valid one cycle after fifo_read_en is sampled.
REQ-008 fifo_read_en  out  1  FIFO pop request (combinational).
REQ-009 m_valid  out  1  stream data valid.
REQ-010 m_ready  in  1  downstream accepts the beat when m_valid and m_ready are both 1.
REQ-011 m_data  out  DATA_WIDTH  stream data; equals the buffer head.
REQ-012 m_last  out  1  1 on the final beat of each PKT_LEN-beat packet.
REQ-013 pkt_count  out  16  number of completed packets; wraps 65535 -> 0.
REQ-014 busy  out  1  1 when inflight=1 or occupancy>0.

Function
REQ-015 The block SHALL hold a 2-entry FIFO-ordered skid buffer (occ 0..2) and an inflight bit that registers fifo_read_en.
REQ-016 The block SHALL drive fifo_read_en = enable & !fifo_empty & ((occ + inflight - pop) < 2), where pop = m_valid & m_ready.
REQ-017 The block SHALL write fifo_dout into the buffer tail on every rising edge where inflight=1, giving a 2-cycle latency from fifo_read_en to m_valid.
REQ-018 The block SHALL assert m_valid exactly when occ>0 and SHALL hold m_data and m_last stable while m_valid=1 and m_ready=0.
REQ-019 A capture and a pop on the same edge SHALL leave occ unchanged and preserve order.
REQ-020 With m_ready held at 1 and the FIFO non-empty, the block SHALL sustain one beat per cycle.
REQ-021 The block SHALL never overflow the buffer; a capture with occ=2 and no pop is unreachable, and the bench flags it as an error.
REQ-022 The 16-bit beat counter SHALL increment on each pop; m_last = (beat_cnt == PKT_LEN-1).
REQ-023 A pop with m_last=1 SHALL reset beat_cnt to 0 and increment pkt_count.
REQ-024 Deasserting enable SHALL block new reads only; the inflight word and buffered words SHALL still be delivered.
REQ-025 States: IDLE (occ=0, inflight=0), FETCH (inflight=1 or occ>0 with enable=1), DRAIN (enable=0, busy=1).
REQ-026 Transitions: IDLE->FETCH on fifo_read_en; FETCH->DRAIN on enable falling; DRAIN->IDLE when busy falls; DRAIN->FETCH on enable=1.
REQ-027 fifo_empty=1 with enable=1 SHALL NOT change the state; FETCH drains to IDLE naturally.

Reset
REQ-028 While reset=0, the block SHALL force the following, asynchronously:
  - occ=0, inflight=0, beat_cnt=0, pkt_count=0, state=IDLE;
  - m_valid=0, m_last=0, m_data=0, busy=0, fifo_read_en=0.
REQ-029 Reset asserted mid-packet SHALL discard buffered and inflight data; the first beat after release starts a new packet.
REQ-030 fifo_read_en SHALL stay 0 for the first cycle after reset release.

Structure
REQ-031 A shared package fifo_stream_pkg SHALL hold:
  - the state enum (IDLE, FETCH, DRAIN);
  - the DATA_WIDTH default;
  - the PKT_LEN default.
REQ-032 The skid buffer SHALL be one sub-module, stream_skid_buf: 2 entries, push/pop, occ output. Counters and the FSM stay in the top module.

Verification
REQ-033 Empty FIFO, enable=1, m_ready=1 for 10 cycles -> fifo_read_en=0, m_valid=0, state IDLE.
REQ-034 8 words preloaded (0xA0..0xA7), m_ready=1 -> beats appear back-to-back in order starting 2 cycles after the first read; m_last only on 0xA7; pkt_count=1.
REQ-035 Same preload, m_ready toggling 1,0,1,0 -> no loss or duplication, m_data stable while stalled, at most 2 reads outstanding.
REQ-036 enable dropped the cycle after fifo_read_en=1 -> that word is still delivered, no further reads, DRAIN->IDLE, busy=0.
REQ-037 Reset pulsed after 3 of 8 beats, then 8 new words -> m_last on the 8th new beat, pkt_count=1.
REQ-038 PKT_LEN=1, 65536 beats -> m_last on every beat, pkt_count wraps to 0.
